window7x7_gen: RTL and testbench

// - Streaming 7x7 neighbourhood generator that produces the row windows the conv block consumes.
// - Accepts a raster-order 8-bit pixel stream: left to right, then top to bottom, one image of a stereo pair.
// - Stores the six previous lines in line buffers and shifts a 7x7 register window by one column per accepted pixel.
// - Presents a window only when all 49 pixels lie inside the image (valid-region output, no padding).

---
 rtl/window7x7_gen.sv | 58 +++++
 tb/tb_window7x7_gen.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/window7x7_gen.sv
// window7x7_gen: streaming 7x7 valid-region window generator over raster pixels
module window7x7_gen #(
    parameter int IMG_W = 640,
    parameter int IMG_H = 480,
    parameter int XW = $clog2(IMG_W),
    parameter int YW = $clog2(IMG_H)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          pix_valid,
    input  logic          pix_sof,
    input  logic [7:0]    pix_data,
    output logic          win_valid,
    output logic [391:0]  win_data,
    output logic [XW-1:0] win_x,
    output logic [YW-1:0] win_y,
    output logic          frame_done
);
    localparam logic [XW-1:0] X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(IMG_H - 1);
    logic [7:0]    lb [6][IMG_W];
    logic [7:0]    v [7];
    logic [XW-1:0] col, cx;
    logic [YW-1:0] row, cy;
    logic          last;
    // sof overrides the counters so the current pixel is (0,0); gather the column vector
    always_comb begin
        cx = pix_sof ? '0 : col;
        cy = pix_sof ? '0 : row;
        last = cx == X_LAST && cy == Y_LAST;
        for (int r = 0; r < 6; r++) v[r] = lb[r][cx];
        v[6] = pix_data;
    end
    // line buffers: each column slot moves up one line and takes the new pixel
    always_ff @(posedge clk)
        if (pix_valid) for (int r = 0; r < 6; r++) lb[r][cx] <= v[r+1];
    // counters, window shift and registered outputs
    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            col <= '0;
            row <= '0;
            win_data <= '0;
            win_valid <= 1'b0;
            win_x <= '0;
            win_y <= '0;
            frame_done <= 1'b0;
        end else begin
            win_valid <= pix_valid && cx >= XW'(6) && cy >= YW'(6);
            frame_done <= pix_valid && last;
            if (pix_valid) begin
                col <= cx == X_LAST ? '0 : cx + XW'(1);
                row <= cx != X_LAST ? cy : cy == Y_LAST ? '0 : cy + YW'(1);
                win_x <= cx - XW'(3);
                win_y <= cy - YW'(3);
                for (int r = 0; r < 7; r++) win_data[r*56 +: 56] <= {v[r], win_data[r*56+8 +: 48]};
            end
        end
endmodule

// File: tb/tb_window7x7_gen.sv
// tb_window7x7_gen: randomized and directed checks of window7x7_gen against an image-array model
module tb_window7x7_gen;
    localparam int W = 8;
    localparam int H = 8;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pix_valid = 1'b0;
    logic pix_sof = 1'b0;
    logic [7:0] pix_data = 8'h00;
    logic win_valid, frame_done;
    logic [391:0] win_data;
    logic [2:0] win_x, win_y;
    int total = 0;
    int bad = 0;
    int err, nwin, nfd, nhi, nstep, first_step, fx, fy;
    logic [391:0] fdata;
    int mx = 0;
    int my = 0;
    int img [H][W];

    always #5 clk = ~clk;

    window7x7_gen #(.IMG_W(W), .IMG_H(H)) dut (
        .clk(clk), .rst(rst), .pix_valid(pix_valid), .pix_sof(pix_sof), .pix_data(pix_data),
        .win_valid(win_valid), .win_data(win_data), .win_x(win_x), .win_y(win_y), .frame_done(frame_done)
    );

    task automatic clear_stats();
        err = 0; nwin = 0; nfd = 0; nhi = 0; nstep = 0; first_step = -1; fx = -1; fy = -1; fdata = '0;
    endtask

    // one clock: model predicts from the image seen so far, DUT output is compared 1 after the edge
    task automatic step(input logic v, input logic s, input logic [7:0] d);
        logic ev, efd, hi;
        logic [391:0] ed, pre;
        logic [2:0] ex, ey, px, py;
        ev = 1'b0; efd = 1'b0; ed = '0; ex = 3'd0; ey = 3'd0;
        pre = win_data; px = win_x; py = win_y;
        if (v) begin
            if (s) begin mx = 0; my = 0; end
            img[my][mx] = d;
            ev = mx >= 6 && my >= 6;
            efd = mx == W-1 && my == H-1;
            if (ev)
                for (int r = 0; r < 7; r++)
                    for (int c = 0; c < 7; c++) ed[(r*7+c)*8 +: 8] = 8'(img[my-6+r][mx-6+c]);
            ex = 3'(mx - 3); ey = 3'(my - 3);
            mx++;
            if (mx == W) begin mx = 0; my++; if (my == H) my = 0; end
        end
        pix_valid = v; pix_sof = s; pix_data = d;
        @(posedge clk); #1;
        nstep++;
        if (win_valid !== ev || frame_done !== efd) err++;
        if (ev && (win_data !== ed || win_x !== ex || win_y !== ey)) err++;
        if (!v && (win_data !== pre || win_x !== px || win_y !== py)) err++;
        if (win_valid) begin
            nwin++;
            if (first_step < 0) begin first_step = nstep; fx = win_x; fy = win_y; fdata = win_data; end
            hi = 1'b1;
            for (int i = 0; i < 49; i++) if (!win_data[i*8+7]) hi = 1'b0;
            if (hi) nhi++;
        end
        if (frame_done) nfd++;
    endtask

    task automatic frame(input int off, input logic sof, input logic toggle);
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++) begin
                step(1'b1, sof && x == 0 && y == 0, 8'(y*16 + x + off));
                if (toggle) step(1'b0, 1'b0, 8'h00);
            end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (win_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", win_valid); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b want 0", frame_done); end
        total++; if (win_data !== '0) begin bad++; $display("FAIL rst_data: got %h want 0", win_data); end
        total++; if (win_x !== 3'd0) begin bad++; $display("FAIL rst_x: got %0d want 0", win_x); end
        total++; if (win_y !== 3'd0) begin bad++; $display("FAIL rst_y: got %0d want 0", win_y); end
        rst = 1'b0;
        clear_stats();
        repeat (3) step(1'b0, 1'($urandom), 8'($urandom));
        total++; if ({win_valid, frame_done, win_x, win_y, win_data} !== '0) begin bad++; $display("FAIL post_rst_outputs: got %h want 0", {win_valid, frame_done, win_x, win_y, win_data}); end
        total++; if (err !== 0) begin bad++; $display("FAIL post_rst_idle: got %0d errors want 0", err); end
    endtask

    task automatic test_full_frame();
        clear_stats();
        frame(0, 1'b1, 1'b0);
        total++; if (err !== 0) begin bad++; $display("FAIL full_model: got %0d errors want 0", err); end
        total++; if (nwin !== 4) begin bad++; $display("FAIL full_nwin: got %0d want 4", nwin); end
        total++; if (nfd !== 1) begin bad++; $display("FAIL full_nfd: got %0d want 1", nfd); end
        total++; if (first_step !== 55) begin bad++; $display("FAIL full_first: got %0d want 55", first_step); end
        total++; if (fx !== 3 || fy !== 3) begin bad++; $display("FAIL full_xy: got %0d,%0d want 3,3", fx, fy); end
        total++; if (fdata[24*8 +: 8] !== 8'h33) begin bad++; $display("FAIL full_centre: got %h want 33", fdata[24*8 +: 8]); end
        total++; if (fdata[0 +: 8] !== 8'h00 || fdata[48 +: 8] !== 8'h06) begin bad++; $display("FAIL full_top: got %h,%h want 00,06", fdata[0 +: 8], fdata[48 +: 8]); end
        total++; if (fdata[336 +: 8] !== 8'h60 || fdata[384 +: 8] !== 8'h66) begin bad++; $display("FAIL full_bottom: got %h,%h want 60,66", fdata[336 +: 8], fdata[384 +: 8]); end
    endtask

    task automatic test_toggle();
        clear_stats();
        frame(0, 1'b1, 1'b1);
        total++; if (err !== 0) begin bad++; $display("FAIL toggle_model: got %0d errors want 0", err); end
        total++; if (nwin !== 4) begin bad++; $display("FAIL toggle_nwin: got %0d want 4", nwin); end
        total++; if (nfd !== 1) begin bad++; $display("FAIL toggle_nfd: got %0d want 1", nfd); end
        total++; if (first_step !== 109) begin bad++; $display("FAIL toggle_first: got %0d want 109", first_step); end
    endtask

    task automatic test_back_to_back();
        clear_stats();
        frame(0, 1'b1, 1'b0);
        frame(128, 1'b1, 1'b0);
        total++; if (err !== 0) begin bad++; $display("FAIL b2b_model: got %0d errors want 0", err); end
        total++; if (nwin !== 8) begin bad++; $display("FAIL b2b_nwin: got %0d want 8", nwin); end
        total++; if (nhi !== 4) begin bad++; $display("FAIL b2b_offset: got %0d want 4", nhi); end
        total++; if (nfd !== 2) begin bad++; $display("FAIL b2b_nfd: got %0d want 2", nfd); end
    endtask

    task automatic test_sof_restart();
        clear_stats();
        for (int k = 0; k < 59; k++) step(1'b1, k == 0, 8'((k/W)*16 + k%W));
        total++; if (err !== 0 || nwin !== 2) begin bad++; $display("FAIL sof_prefix: got err=%0d nwin=%0d want 0,2", err, nwin); end
        clear_stats();
        frame(64, 1'b1, 1'b0);
        total++; if (err !== 0) begin bad++; $display("FAIL sof_model: got %0d errors want 0", err); end
        total++; if (nwin !== 4 || nfd !== 1) begin bad++; $display("FAIL sof_counts: got nwin=%0d nfd=%0d want 4,1", nwin, nfd); end
        total++; if (first_step !== 55) begin bad++; $display("FAIL sof_first: got %0d want 55", first_step); end
        total++; if (fx !== 3 || fy !== 3) begin bad++; $display("FAIL sof_xy: got %0d,%0d want 3,3", fx, fy); end
    endtask

    task automatic test_reset_mid();
        clear_stats();
        for (int k = 0; k < 30; k++) step(1'b1, k == 0, 8'($urandom));
        rst = 1'b1; pix_valid = 1'b0; pix_sof = 1'b0;
        #1;
        total++; if ({win_valid, frame_done, win_x, win_y, win_data} !== '0) begin bad++; $display("FAIL midrst_async: got %h want 0", {win_valid, frame_done, win_x, win_y, win_data}); end
        repeat (2) @(posedge clk);
        #1;
        total++; if ({win_valid, frame_done, win_x, win_y, win_data} !== '0) begin bad++; $display("FAIL midrst_hold: got %h want 0", {win_valid, frame_done, win_x, win_y, win_data}); end
        rst = 1'b0; mx = 0; my = 0;
        clear_stats();
        frame(0, 1'b0, 1'b0);
        total++; if (err !== 0) begin bad++; $display("FAIL midrst_model: got %0d errors want 0", err); end
        total++; if (nwin !== 4 || nfd !== 1) begin bad++; $display("FAIL midrst_counts: got nwin=%0d nfd=%0d want 4,1", nwin, nfd); end
    endtask

    task automatic test_random();
        for (int f = 0; f < 3; f++) begin
            clear_stats();
            for (int k = 0; k < W*H; k++) begin
                step(1'b1, k == 0, 8'($urandom));
                repeat ($urandom_range(0, 2)) step(1'b0, 1'($urandom), 8'($urandom));
            end
            total++; if (err !== 0) begin bad++; $display("FAIL rand_model[%0d]: got %0d errors want 0", f, err); end
            total++; if (nwin !== 4 || nfd !== 1) begin bad++; $display("FAIL rand_counts[%0d]: got nwin=%0d nfd=%0d want 4,1", f, nwin, nfd); end
        end
    endtask

    initial begin
        test_reset();
        test_full_frame();
        test_toggle();
        test_back_to_back();
        test_sof_restart();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
